bias_bram_loader: RTL and testbench
===================================

// Module: bias_bram_loader
// PURPOSE
//  Upstream feeder of the bias BRAM controller. Accepts a byte-serial stream of
//  B_BW-bit bias values over a valid/ready handshake and packs LANES values per
//  MEM_SIZE-bit word. Issues one single-cycle write per word on the controller's
//  port-A write interface (din_a/addr_a/we_a), with addresses 0..MEM_DEPTH-1.
//  Runs one load per start pulse and reports completion and the word count.
// PARAMETERS
//  B_BW       8    bits per bias value
//  LANES      5    bias values per BRAM word (LANES*B_BW == MEM_SIZE)
//  MEM_SIZE   40   BRAM word width
//  MEM_DEPTH  49   BRAM depth, i.e. max words per load
//  ADDR_W     6    address width, >= clog2(MEM_DEPTH)
// PORTS
//  clk        in   1         clock
//  rst        in   1         synchronous active-high reset
//  start      in   1         begin a load; sampled in IDLE only
//  s_data     in   B_BW      bias value
//  s_valid    in   1         s_data valid
//  s_last     in   1         final value of the load, qualified by s_valid
//  s_ready    out  1         loader accepts s_data this cycle
//  din_a      out  MEM_SIZE  packed word to the BRAM controller
//  addr_a     out  ADDR_W    word address
//  we_a       out  1         write strobe, one cycle per word
//  busy       out  1         high in every state except IDLE
//  done       out  1         one-cycle pulse at end of load
//  words      out  ADDR_W+1  words written in the current or last load
// BEHAVIOUR
//  Reset: state=IDLE. s_ready, we_a, busy and done are 0. din_a, addr_a, words,
//   the lane counter and the pack register are 0.
//  States are IDLE, PACK, WRITE and DONE.
//  IDLE: s_ready=0. When start=1: go to PACK and clear words, the lane counter,
//   the word index and the pack register.
//  PACK: s_ready=1. A beat is accepted when s_valid & s_ready. The value goes into
//   lane lane_cnt at bits [lane_cnt*B_BW +: B_BW], so lane 0 is the LSBs and holds
//   the first value of the word. lane_cnt then increments.
//   Go to WRITE when the accepted beat fills lane LANES-1 or has s_last=1.
//   On s_last the unfilled upper lanes stay 0 (zero padding).
//  WRITE: s_ready=0. we_a=1 for exactly one cycle, with din_a=pack register and
//   addr_a=word index, both registered and stable while we_a=1.
//   On exit: words+1, word index+1, lane_cnt=0, pack register cleared.
//   Go to DONE if s_last was captured or the word index == MEM_DEPTH-1.
//   Otherwise go back to PACK.
//  DONE: done=1 for one cycle, then go to IDLE. words holds its value until the next start.
//  Latency: we_a rises in the cycle after the edge that accepted the word's last beat.
//   s_ready is low for that write cycle, so a word costs a minimum of LANES+1 cycles.
//  Boundary conditions:
//  - A full MEM_DEPTH load terminates without s_last. Beats offered afterwards
//    are not accepted, because s_ready=0 in IDLE.
//  - s_last on lane 0 writes a word with only lane 0 non-zero.
//  - start while busy is ignored.
//  - s_valid with s_ready=0 is stalled and not dropped; s_data and s_last must be held.
//  - rst mid-load returns to reset values in the next cycle. No partial word is written.
//  - addr_a never exceeds MEM_DEPTH-1.
//  - s_last outside PACK is ignored.
// TESTING
//  1. start, 10 beats 0x01..0x0A with s_last on 0x0A, s_valid=1 -> two writes:
//     addr0=0x0504030201, addr1=0x0A09080706. Then done, words=2.
//  2. Continuous stream of 245 beats, no s_last -> 49 writes at addr 0..48.
//     done after the write to addr 48. words=49; s_ready=0 afterwards.
//  3. 7 beats 0x11..0x17 with s_last on 0x17 -> addr1 receives 0x0000001716
//     (padded). words=2.
//  4. Random s_valid gaps (about 50%) with 10 beats as in test 1 -> identical
//     write data and addresses. we_a is never high for 2 consecutive cycles.
//  5. rst asserted after 3 beats of a word -> no we_a. All outputs at reset values.
//     A new start then writes addr 0 first.
//  6. start pulsed again during PACK -> no effect; words and addresses continue
//     unchanged.

Source files
------------

// File: rtl/bias_bram_loader.sv
// Bias BRAM loader: packs a byte-serial bias stream into LANES-wide words and
// writes them one at a time to the BRAM controller's port A.

// One lane of the pack register. It is cleared at load start and after each
// word is written, and it captures a beat when its lane is selected.
module bias_lane #(
  parameter int B_BW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            we,
  input  logic [B_BW-1:0] d,
  output logic [B_BW-1:0] q
);
  // Lane storage with a synchronous clear.
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (we)    q <= d;
  end
endmodule

module bias_bram_loader #(
  parameter int B_BW      = 8,
  parameter int LANES     = 5,
  parameter int MEM_SIZE  = 40,
  parameter int MEM_DEPTH = 49,
  parameter int ADDR_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [B_BW-1:0]     s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic [MEM_SIZE-1:0] din_a,
  output logic [ADDR_W-1:0]   addr_a,
  output logic                we_a,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     words
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

  state_t                       state_q, state_d;
  logic [LW-1:0]                lane_cnt;
  logic [ADDR_W-1:0]            widx;
  logic [ADDR_W:0]              words_q;
  logic                         last_q;
  logic [LANES-1:0][B_BW-1:0]   lanes;
  logic                         acc, lane_full, widx_end, clr;

  assign acc       = s_valid && (state_q == PACK);
  assign lane_full = (lane_cnt == LW'(LANES-1));
  assign widx_end  = (widx == ADDR_W'(MEM_DEPTH-1));
  assign clr       = ((state_q == IDLE) && start) || (state_q == WRITE);

  // din_a and addr_a are taken directly from registers, so they stay stable
  // through the single WRITE cycle.
  assign din_a  = lanes;
  assign addr_a = widx;
  assign words  = words_q;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      bias_lane #(.B_BW(B_BW)) u_lane (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .we  (acc && (lane_cnt == LW'(g))),
        .d   (s_data),
        .q   (lanes[g])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    we_a    = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = PACK;
      end
      PACK: begin
        s_ready = 1'b1;
        if (acc && (lane_full || s_last)) state_d = WRITE;
      end
      WRITE: begin
        we_a    = 1'b1;
        state_d = (last_q || widx_end) ? DONE : PACK;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters and the end-of-load flag. The word index is held on the final
  // word so that addr_a never points past the last BRAM entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      widx     <= '0;
      words_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          lane_cnt <= '0;
          widx     <= '0;
          words_q  <= '0;
          last_q   <= 1'b0;
        end
        PACK: if (acc) begin
          lane_cnt <= lane_cnt + 1'b1;
          if (s_last) last_q <= 1'b1;
        end
        WRITE: begin
          words_q  <= words_q + 1'b1;
          lane_cnt <= '0;
          if (!(last_q || widx_end)) widx <= widx + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bias_bram_loader.sv
// Directed and randomized bench for bias_bram_loader with a word-packing model.
module tb_bias_bram_loader;
  localparam int B_BW = 8, LANES = 5, MEM_SIZE = 40, MEM_DEPTH = 49, ADDR_W = 6;

  logic                clk = 0;
  logic                rst = 1;
  logic                start = 0;
  logic [B_BW-1:0]     s_data = '0;
  logic                s_valid = 0;
  logic                s_last = 0;
  logic                s_ready, we_a, busy, done;
  logic [MEM_SIZE-1:0] din_a;
  logic [ADDR_W-1:0]   addr_a;
  logic [ADDR_W:0]     words;

  int errors = 0;
  int checks = 0;

  logic [7:0]  beat[$];
  logic [39:0] exp_data[$], cap_data[$];
  int          exp_addr[$], cap_addr[$];
  logic        prev_we = 0;

  bias_bram_loader #(.B_BW(B_BW), .LANES(LANES), .MEM_SIZE(MEM_SIZE),
                     .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .din_a(din_a), .addr_a(addr_a),
    .we_a(we_a), .busy(busy), .done(done), .words(words)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write capture: strobe never two cycles in a row, address in range.
  always @(negedge clk) begin
    if (we_a) begin
      chk("we_a_back_to_back", {63'd0, prev_we}, 64'd0);
      chk("addr_in_range", {63'd0, (addr_a <= ADDR_W'(MEM_DEPTH-1))}, 64'd1);
      cap_addr.push_back(int'(addr_a));
      cap_data.push_back(din_a);
    end
    prev_we = we_a;
  end

  // Reference: consecutive groups of LANES beats, first beat in the low byte,
  // short final group zero padded, at most MEM_DEPTH words.
  function automatic void build_exp(input int nb);
    logic [39:0] d;
    exp_addr.delete(); exp_data.delete();
    for (int k = 0; k < MEM_DEPTH && k * LANES < nb; k++) begin
      d = '0;
      for (int j = 0; j < LANES; j++)
        if (k * LANES + j < nb) d = d | (40'(beat[k * LANES + j]) << (8 * j));
      exp_addr.push_back(k);
      exp_data.push_back(d);
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  // Drive beat[0..n-1]; s_last on the final beat if has_last; gap_pct% idle
  // cycles; start re-pulsed alongside beat start_at (ignored while busy).
  task automatic drive(input int n, input bit has_last, input int gap_pct, input int start_at);
    int i = 0, guard = 0;
    bit acc;
    while (i < n && guard < 5000) begin
      guard++;
      if ($urandom_range(99) < gap_pct) begin
        s_valid = 0; tick();
      end else begin
        s_valid = 1; s_data = beat[i]; s_last = has_last && (i == n - 1);
        start = (i == start_at);
        @(negedge clk); acc = s_ready;
        tick(); start = 0;
        if (acc) i++;
      end
    end
    s_valid = 0; s_last = 0; start = 0;
    chk("drive_complete", 64'(i), 64'(n));
  endtask

  task automatic wait_done(input string tag, input int exp_words);
    bit seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk({tag, "_done"}, {63'd0, seen}, 64'd1);
    chk({tag, "_words"}, 64'(words), 64'(exp_words));
    tick();
    chk({tag, "_idle"}, {62'd0, busy, s_ready}, 64'd0);
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_nwrites"}, 64'(cap_data.size()), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
      chk({tag, "_addr"}, 64'(cap_addr[i]), 64'(exp_addr[i]));
      chk({tag, "_data"}, 64'(cap_data[i]), 64'(exp_data[i]));
    end
  endtask

  // Full load: base>=0 gives beats base+1..base+n, otherwise random bytes.
  task automatic run_load(input string tag, input int n, input bit has_last,
                          input int base, input int gap_pct, input int start_at);
    beat.delete();
    for (int i = 0; i < n; i++)
      beat.push_back(base >= 0 ? 8'(base + 1 + i) : 8'($urandom_range(255)));
    build_exp(n);
    cap_addr.delete(); cap_data.delete();
    do_start();
    drive(n, has_last, gap_pct, start_at);
    wait_done(tag, exp_data.size());
    cmp_writes(tag);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_outs", {din_a, addr_a, we_a, busy, done, s_ready}, 64'd0);
    chk("rst_words", 64'(words), 64'd0);
    rst = 0; tick();

    // 1: ten beats 01..0A, s_last on 0A
    run_load("t1", 10, 1, 0, 0, -1);
    if (cap_data.size() == 2) begin
      chk("t1_w0", 64'(cap_data[0]), 64'h05_0403_0201);
      chk("t1_w1", 64'(cap_data[1]), 64'h0A_0908_0706);
    end

    // 2: full-depth stream, no s_last, random data
    run_load("t2", 245, 0, -1, 0, -1);
    cap_data.delete();
    s_valid = 1; s_data = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("t2_no_ready_after", {63'd0, s_ready}, 64'd0);
      tick();
    end
    s_valid = 0;
    chk("t2_no_extra_writes", 64'(cap_data.size()), 64'd0);

    // 3: seven beats 11..17, padded second word
    run_load("t3", 7, 1, 16, 0, -1);
    if (cap_data.size() == 2) chk("t3_pad", 64'(cap_data[1]), 64'h00_0000_1716);

    // s_last on lane 0
    run_load("lane0_last", 6, 1, -1, 0, -1);

    // 4: random gaps, same data as test 1
    run_load("t4", 10, 1, 0, 50, -1);

    // random lengths, gaps and data
    for (int r = 0; r < 3; r++)
      run_load("rand", 1 + $urandom_range(40), 1, -1, 30, -1);

    // 5: reset after three beats of a word
    beat.delete();
    for (int i = 0; i < 3; i++) beat.push_back(8'(i + 1));
    cap_data.delete();
    do_start();
    drive(3, 0, 0, -1);
    rst = 1; tick();
    chk("t5_rst_outs", {din_a, addr_a, we_a, busy, done, s_ready}, 64'd0);
    chk("t5_rst_words", 64'(words), 64'd0);
    rst = 0; tick();
    chk("t5_no_write", 64'(cap_data.size()), 64'd0);
    run_load("t5_restart", 10, 1, 0, 0, -1);

    // 6: start pulsed again mid-load
    run_load("t6", 10, 1, 0, 0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
